mouse_cursor_tracker: RTL and testbench

- Sits downstream of the PS/2 mouse packet receiver and consumes each decoded 3-byte packet: status/button byte, X delta and Y delta.
- Converts relative motion into an absolute, clamped on-screen cursor position for the VGA home-simulation renderer.
- Produces debounced button levels and one-cycle click pulses for the game/control logic.
- Counts malformed or dropped packets for debug display.

---
 rtl/mouse_pkg.sv | 30 +++
 rtl/mouse_cursor_tracker_if.sv | 14 +
 rtl/axis_clamp_accum.sv | 47 ++++
 rtl/mouse_cursor_tracker.sv | 163 ++++++++++++++++
 tb/tb_mouse_cursor_tracker.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse cursor tracker: status bit map, FSM encoding, screen size.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mouse_pkg;

    // Bit positions inside the PS/2 status byte
    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_M   = 2;
    localparam int ALWAYS1 = 3;
    localparam int XSIGN   = 4;
    localparam int YSIGN   = 5;
    localparam int XOVF    = 6;
    localparam int YOVF    = 7;

    // Default screen geometry of the VGA renderer
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // Width of the intermediate signed position sum
    localparam int SUM_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        CALC   = 2'd2,
        COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/mouse_cursor_tracker_if.sv
// Decoded PS/2 packet bus from the packet receiver to the cursor tracker.
// Latency: n/a (wires only).
// Backpressure: none; the receiver strobes packet_valid and the tracker drops what it cannot take.
interface mouse_cursor_tracker_if;

    logic       packet_valid;
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;

    modport master (output packet_valid, output status, output dx, output dy);
    modport slave  (input  packet_valid, input  status, input  dx, input  dy);

endinterface

// File: rtl/axis_clamp_accum.sv
// One cursor axis: signed delta scaling, accumulate onto the position, clamp to the screen.
// Latency: combinational; the caller registers sum_o and feeds it back as sum_i one stage later.
// Backpressure: none.
module axis_clamp_accum
    import mouse_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LIMIT  = 160,
    parameter int SHIFT  = 1,
    parameter bit INVERT = 1'b0
) (
    input  logic [WIDTH-1:0]        pos_i,
    input  logic                    sign_i,
    input  logic [7:0]              mag_i,
    input  logic                    ovf_i,
    output logic signed [SUM_W-1:0] sum_o,
    input  logic signed [SUM_W-1:0] sum_i,
    output logic [WIDTH-1:0]        clamped_o
);

    localparam logic signed [SUM_W-1:0] MAX_POS = SUM_W'(LIMIT - 1);

    logic signed [8:0]       d_raw;
    logic signed [8:0]       d_scaled;
    logic signed [SUM_W-1:0] d_ext;
    logic signed [SUM_W-1:0] pos_ext;

    // Overflowed deltas are discarded; arithmetic shift floors, so -1 stays -1
    always_comb begin
        d_raw    = ovf_i ? 9'sd0 : {sign_i, mag_i};
        d_scaled = d_raw >>> SHIFT;
        d_ext    = {{(SUM_W-9){d_scaled[8]}}, d_scaled};
        pos_ext  = {{(SUM_W-WIDTH){1'b0}}, pos_i};
        sum_o    = INVERT ? (pos_ext - d_ext) : (pos_ext + d_ext);
    end

    // Saturate the registered sum into 0..LIMIT-1
    always_comb begin
        clamped_o = sum_i[WIDTH-1:0];
        if (sum_i[SUM_W-1]) begin
            clamped_o = '0;
        end else if (sum_i > MAX_POS) begin
            clamped_o = MAX_POS[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Turns decoded PS/2 packets into a clamped absolute cursor, button levels and click pulses.
// Latency: capture edge t -> position, buttons and pulses registered on edge t+3, IDLE again from then.
// Backpressure: none; packets arriving while busy are dropped and counted in drop_count.
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int X_INIT      = 80,
    parameter int Y_INIT      = 60,
    parameter int SPEED_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_send,
    mouse_cursor_tracker_if.slave pkt,
    output logic [7:0]           cursor_x,
    output logic [6:0]           cursor_y,
    output logic [2:0]           buttons,
    output logic                 left_click,
    output logic                 right_click,
    output logic                 middle_click,
    output logic                 cursor_moved,
    output logic                 busy,
    output logic                 sync_err,
    output logic [7:0]           drop_count
);

    state_e                  state_q, state_d;
    logic [7:0]              status_q, dx_q, dy_q;
    logic signed [SUM_W-1:0] nx_q, ny_q;
    logic signed [SUM_W-1:0] sum_x, sum_y;
    logic [7:0]              clamp_x;
    logic [6:0]              clamp_y;
    logic [7:0]              cursor_x_q;
    logic [6:0]              cursor_y_q;
    logic [2:0]              buttons_q;
    logic [2:0]              click_q;
    logic                    moved_q;
    logic                    sync_err_q;
    logic [7:0]              drop_q, drop_d;

    logic       capture;
    logic       sync_reject;
    logic       busy_drop;
    logic       do_commit;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    axis_clamp_accum #(
        .WIDTH (8),
        .LIMIT (SCREEN_W),
        .SHIFT (SPEED_SHIFT),
        .INVERT(1'b0)
    ) u_axis_x (
        .pos_i    (cursor_x_q),
        .sign_i   (status_q[XSIGN]),
        .mag_i    (dx_q),
        .ovf_i    (status_q[XOVF]),
        .sum_o    (sum_x),
        .sum_i    (nx_q),
        .clamped_o(clamp_x)
    );

    // PS/2 reports +Y as up while screen rows grow downward, hence the inverted axis
    axis_clamp_accum #(
        .WIDTH (7),
        .LIMIT (SCREEN_H),
        .SHIFT (SPEED_SHIFT),
        .INVERT(1'b1)
    ) u_axis_y (
        .pos_i    (cursor_y_q),
        .sign_i   (status_q[YSIGN]),
        .mag_i    (dy_q),
        .ovf_i    (status_q[YOVF]),
        .sum_o    (sum_y),
        .sum_i    (ny_q),
        .clamped_o(clamp_y)
    );

    // Qualifying events; with enable_send low nothing is captured, counted or committed
    always_comb begin
        capture     = (state_q == IDLE)   && enable_send && pkt.packet_valid;
        busy_drop   = (state_q != IDLE)   && enable_send && pkt.packet_valid;
        sync_reject = (state_q == CHECK)  && enable_send && !status_q[ALWAYS1];
        do_commit   = (state_q == COMMIT) && enable_send;
        drop_inc    = {1'b0, busy_drop} + {1'b0, sync_reject};
        drop_sum    = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d      = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Next-state: one cycle per stage, any stage aborts to IDLE when enable_send drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = CHECK;
            CHECK:   state_d = (!enable_send || !status_q[ALWAYS1]) ? IDLE : CALC;
            CALC:    state_d = enable_send ? COMMIT : IDLE;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet capture, position pipeline, button/pulse and drop counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            cursor_x_q <= 8'(X_INIT);
            cursor_y_q <= 7'(Y_INIT);
            buttons_q  <= '0;
            click_q    <= '0;
            moved_q    <= 1'b0;
            sync_err_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            sync_err_q <= sync_reject;
            click_q    <= '0;
            moved_q    <= 1'b0;
            drop_q     <= drop_d;
            if (capture) begin
                status_q <= pkt.status;
                dx_q     <= pkt.dx;
                dy_q     <= pkt.dy;
            end
            if (state_q == CALC) begin
                nx_q <= sum_x;
                ny_q <= sum_y;
            end
            if (do_commit) begin
                cursor_x_q <= clamp_x;
                cursor_y_q <= clamp_y;
                buttons_q  <= status_q[BTN_M:BTN_L];
                click_q    <= status_q[BTN_M:BTN_L] & ~buttons_q;
                moved_q    <= (clamp_x != cursor_x_q) || (clamp_y != cursor_y_q);
            end
        end
    end

    assign cursor_x     = cursor_x_q;
    assign cursor_y     = cursor_y_q;
    assign buttons      = buttons_q;
    assign left_click   = click_q[BTN_L];
    assign right_click  = click_q[BTN_R];
    assign middle_click = click_q[BTN_M];
    assign cursor_moved = moved_q;
    assign busy         = (state_q != IDLE);
    assign sync_err     = sync_err_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: directed scenarios plus random packets against an integer model.
// Latency: pulses and position expected three edges after the capture edge.
// Backpressure: packets sent while busy are expected to be counted as drops.
module tb_mouse_cursor_tracker;

    localparam int SHIFT = 1;

    logic       clk;
    logic       reset;
    logic       enable_send;
    logic [7:0] cursor_x;
    logic [6:0] cursor_y;
    logic [2:0] buttons;
    logic       left_click, right_click, middle_click;
    logic       cursor_moved, busy, sync_err;
    logic [7:0] drop_count;

    mouse_cursor_tracker_if pkt_if();

    mouse_cursor_tracker #(
        .SCREEN_W(160), .SCREEN_H(120), .X_INIT(80), .Y_INIT(60), .SPEED_SHIFT(SHIFT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_send (enable_send),
        .pkt         (pkt_if),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .buttons     (buttons),
        .left_click  (left_click),
        .right_click (right_click),
        .middle_click(middle_click),
        .cursor_moved(cursor_moved),
        .busy        (busy),
        .sync_err    (sync_err),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int       exp_x, exp_y, exp_drop;
    bit [2:0] exp_btn, exp_click;
    bit       exp_moved, exp_sync;

    // Observations of one packet
    logic [7:0] o_x, o_drop;
    logic [6:0] o_y;
    logic [2:0] o_btn, o_click3, o_click_other;
    logic       o_moved3, o_moved_other, o_sync1, o_sync_other, o_busy1, o_busy3;

    function automatic int axis_model(int pos, bit sgn, bit [7:0] mag, bit ovf, bit inv, int lim);
        int d, div, sc, n;
        d   = ovf ? 0 : (sgn ? int'(mag) - 256 : int'(mag));
        div = 1 << SHIFT;
        sc  = (d >= 0) ? d / div : -((-d + div - 1) / div);
        n   = inv ? pos - sc : pos + sc;
        if (n < 0) n = 0;
        if (n > lim - 1) n = lim - 1;
        return n;
    endfunction

    task automatic model_reset();
        exp_x = 80; exp_y = 60; exp_btn = 3'b000; exp_drop = 0;
    endtask

    task automatic model_pkt(input bit [7:0] st, input bit [7:0] mx, input bit [7:0] my);
        int nx, ny;
        exp_sync = ~st[3];
        exp_click = 3'b000;
        exp_moved = 1'b0;
        if (!st[3]) begin
            exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
        end else begin
            nx = axis_model(exp_x, st[4], mx, st[6], 1'b0, 160);
            ny = axis_model(exp_y, st[5], my, st[7], 1'b1, 120);
            exp_moved = (nx != exp_x) || (ny != exp_y);
            exp_click = st[2:0] & ~exp_btn;
            exp_btn = st[2:0];
            exp_x = nx;
            exp_y = ny;
        end
    endtask

    task automatic run_pkt(input logic [7:0] st, input logic [7:0] mx, input logic [7:0] my);
        @(negedge clk);
        pkt_if.packet_valid = 1'b1;
        pkt_if.status = st; pkt_if.dx = mx; pkt_if.dy = my;
        @(posedge clk); #1;
        pkt_if.packet_valid = 1'b0;
        o_click_other = 3'b000; o_moved_other = 1'b0; o_sync_other = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                o_sync1 = sync_err; o_busy1 = busy;
            end else begin
                o_sync_other |= sync_err;
            end
            if (k == 3) begin
                o_x = cursor_x; o_y = cursor_y; o_btn = buttons; o_busy3 = busy;
                o_click3 = {middle_click, right_click, left_click}; o_moved3 = cursor_moved;
            end else begin
                o_click_other |= {middle_click, right_click, left_click};
                o_moved_other |= cursor_moved;
            end
        end
        o_drop = drop_count;
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #1;
        checks++; if (cursor_x !== 8'd80) begin failures++; $display("FAIL reset_x got=%0d exp=80", cursor_x); end
        checks++; if (cursor_y !== 7'd60) begin failures++; $display("FAIL reset_y got=%0d exp=60", cursor_y); end
        checks++; if (buttons !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL reset_btn_busy got=%b/%b exp=000/0", buttons, busy); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    endtask

    task automatic test_motion();
        run_pkt(8'h08, 8'h0A, 8'h00); model_pkt(8'h08, 8'h0A, 8'h00);
        checks++; if (o_x !== 8'd85) begin failures++; $display("FAIL move_right_x got=%0d exp=85", o_x); end
        checks++; if (o_moved3 !== 1'b1 || o_moved_other !== 1'b0) begin failures++; $display("FAIL move_right_pulse got=%b/%b exp=1/0", o_moved3, o_moved_other); end
        checks++; if (o_busy1 !== 1'b1 || o_busy3 !== 1'b0) begin failures++; $display("FAIL move_busy got=%b/%b exp=1/0", o_busy1, o_busy3); end
        run_pkt(8'h18, 8'hF6, 8'h00); model_pkt(8'h18, 8'hF6, 8'h00);
        checks++; if (o_x !== 8'd80) begin failures++; $display("FAIL move_left_x got=%0d exp=80", o_x); end
        run_pkt(8'h08, 8'h00, 8'h14); model_pkt(8'h08, 8'h00, 8'h14);
        checks++; if (o_y !== 7'd50) begin failures++; $display("FAIL move_up_y got=%0d exp=50", o_y); end
    endtask

    task automatic test_clamp();
        run_pkt(8'h08, 8'hFF, 8'h00); model_pkt(8'h08, 8'hFF, 8'h00);
        run_pkt(8'h08, 8'hFF, 8'h00); model_pkt(8'h08, 8'hFF, 8'h00);
        checks++; if (o_x !== 8'd159) begin failures++; $display("FAIL clamp_hi_x got=%0d exp=159", o_x); end
        checks++; if (o_moved3 !== 1'b0) begin failures++; $display("FAIL clamp_hi_nomove got=%b exp=0", o_moved3); end
        run_pkt(8'h18, 8'h00, 8'h00); model_pkt(8'h18, 8'h00, 8'h00);
        run_pkt(8'h18, 8'h00, 8'h00); model_pkt(8'h18, 8'h00, 8'h00);
        checks++; if (o_x !== 8'd0) begin failures++; $display("FAIL clamp_lo_x got=%0d exp=0", o_x); end
        run_pkt(8'h18, 8'hF0, 8'h00); model_pkt(8'h18, 8'hF0, 8'h00);
        checks++; if (o_x !== 8'd0 || o_moved3 !== 1'b0) begin failures++; $display("FAIL clamp_lo_nomove got=%0d/%b exp=0/0", o_x, o_moved3); end
    endtask

    task automatic test_buttons();
        run_pkt(8'h09, 8'h00, 8'h00); model_pkt(8'h09, 8'h00, 8'h00);
        checks++; if (o_btn !== 3'b001 || o_click3 !== 3'b001 || o_click_other !== 3'b000) begin failures++; $display("FAIL left_press got=%b/%b/%b exp=001/001/000", o_btn, o_click3, o_click_other); end
        run_pkt(8'h09, 8'h00, 8'h00); model_pkt(8'h09, 8'h00, 8'h00);
        checks++; if (o_btn !== 3'b001 || o_click3 !== 3'b000) begin failures++; $display("FAIL left_hold got=%b/%b exp=001/000", o_btn, o_click3); end
        run_pkt(8'h08, 8'h00, 8'h00); model_pkt(8'h08, 8'h00, 8'h00);
        checks++; if (o_btn !== 3'b000 || o_click3 !== 3'b000) begin failures++; $display("FAIL left_release got=%b/%b exp=000/000", o_btn, o_click3); end
        run_pkt(8'h0E, 8'h00, 8'h00); model_pkt(8'h0E, 8'h00, 8'h00);
        checks++; if (o_btn !== 3'b110 || o_click3 !== 3'b110) begin failures++; $display("FAIL right_middle got=%b/%b exp=110/110", o_btn, o_click3); end
    endtask

    task automatic test_ovf_sync();
        logic [7:0] x0;
        x0 = 8'(exp_x);
        run_pkt(8'h48, 8'h50, 8'h00); model_pkt(8'h48, 8'h50, 8'h00);
        checks++; if (o_x !== x0 || o_btn !== 3'b000) begin failures++; $display("FAIL x_overflow got=%0d/%b exp=%0d/000", o_x, o_btn, x0); end
        run_pkt(8'h00, 8'h50, 8'h50); model_pkt(8'h00, 8'h50, 8'h50);
        checks++; if (o_sync1 !== 1'b1 || o_sync_other !== 1'b0) begin failures++; $display("FAIL sync_pulse got=%b/%b exp=1/0", o_sync1, o_sync_other); end
        checks++; if (o_drop !== 8'd1) begin failures++; $display("FAIL sync_drop got=%0d exp=1", o_drop); end
        checks++; if (o_x !== x0 || o_btn !== 3'b000 || o_moved3 !== 1'b0) begin failures++; $display("FAIL sync_nochange got=%0d/%b/%b exp=%0d/000/0", o_x, o_btn, o_moved3, x0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pkt_if.packet_valid = 1'b1; pkt_if.status = 8'h08; pkt_if.dx = 8'h28; pkt_if.dy = 8'h00;
        @(posedge clk); #1;
        pkt_if.status = 8'h09; pkt_if.dx = 8'h7F; pkt_if.dy = 8'h7F;
        @(posedge clk); #1;
        pkt_if.packet_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_pkt(8'h08, 8'h28, 8'h00);
        exp_drop = exp_drop + 1;
        checks++; if (cursor_x !== 8'(exp_x) || buttons !== 3'b000) begin failures++; $display("FAIL b2b_commit got=%0d/%b exp=%0d/000", cursor_x, buttons, exp_x); end
        checks++; if (drop_count !== 8'(exp_drop)) begin failures++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_count, exp_drop); end
    endtask

    task automatic test_enable();
        logic moved_seen;
        @(negedge clk);
        pkt_if.packet_valid = 1'b1; pkt_if.status = 8'h0F; pkt_if.dx = 8'h20; pkt_if.dy = 8'h20;
        @(posedge clk); #1;
        pkt_if.packet_valid = 1'b0;
        enable_send = 1'b0;
        moved_seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; moved_seen |= cursor_moved | left_click; end
        checks++; if (cursor_x !== 8'(exp_x) || cursor_y !== 7'(exp_y) || buttons !== exp_btn) begin failures++; $display("FAIL abort_hold got=%0d,%0d,%b exp=%0d,%0d,%b", cursor_x, cursor_y, buttons, exp_x, exp_y, exp_btn); end
        checks++; if (moved_seen !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_pulse got=%b/%b exp=0/0", moved_seen, busy); end
        pkt_if.packet_valid = 1'b1; pkt_if.status = 8'h00;
        repeat (3) begin @(posedge clk); #1; end
        pkt_if.packet_valid = 1'b0;
        checks++; if (busy !== 1'b0 || drop_count !== 8'(exp_drop) || sync_err !== 1'b0) begin failures++; $display("FAIL disabled_ignore got=%b/%0d exp=0/%0d", busy, drop_count, exp_drop); end
        enable_send = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] st, mx, my;
        for (int n = 0; n < 60; n++) begin
            st = 8'($urandom);
            if ($urandom_range(0, 9) != 0) st[3] = 1'b1;
            mx = 8'($urandom); my = 8'($urandom);
            run_pkt(st, mx, my); model_pkt(st, mx, my);
            checks++;
            if (o_x !== 8'(exp_x) || o_y !== 7'(exp_y) || o_btn !== exp_btn || o_drop !== 8'(exp_drop)) begin
                failures++;
                $display("FAIL rand_state n=%0d st=%h got=%0d,%0d,%b,%0d exp=%0d,%0d,%b,%0d", n, st, o_x, o_y, o_btn, o_drop, exp_x, exp_y, exp_btn, exp_drop);
            end
            checks++;
            if (o_click3 !== exp_click || o_moved3 !== exp_moved || o_sync1 !== exp_sync ||
                o_click_other !== 3'b000 || o_moved_other !== 1'b0 || o_sync_other !== 1'b0) begin
                failures++;
                $display("FAIL rand_pulse n=%0d st=%h got=%b,%b,%b exp=%b,%b,%b", n, st, o_click3, o_moved3, o_sync1, exp_click, exp_moved, exp_sync);
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        pkt_if.packet_valid = 1'b1; pkt_if.status = 8'h00; pkt_if.dx = 8'h00; pkt_if.dy = 8'h00;
        repeat (300) @(posedge clk);
        @(negedge clk);
        pkt_if.packet_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // 300 cycles of rejected packets collide with busy drops far beyond 255 events
        exp_drop = 255;
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL sat_level got=%0d exp=255", drop_count); end
        run_pkt(8'h00, 8'h00, 8'h00); model_pkt(8'h00, 8'h00, 8'h00);
        checks++; if (o_sync1 !== 1'b1 || o_drop !== 8'd255) begin failures++; $display("FAIL sat_sync got=%b/%0d exp=1/255", o_sync1, o_drop); end
    endtask

    task automatic test_reset_mid();
        run_pkt(8'h09, 8'h40, 8'h40); model_pkt(8'h09, 8'h40, 8'h40);
        @(negedge clk);
        pkt_if.packet_valid = 1'b1; pkt_if.status = 8'h0A; pkt_if.dx = 8'h30; pkt_if.dy = 8'h30;
        @(posedge clk); #1;
        pkt_if.packet_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (cursor_x !== 8'd80 || cursor_y !== 7'd60) begin failures++; $display("FAIL midreset_pos got=%0d,%0d exp=80,60", cursor_x, cursor_y); end
        checks++; if (busy !== 1'b0 || buttons !== 3'b000 || drop_count !== 8'd0) begin failures++; $display("FAIL midreset_state got=%b/%b/%0d exp=0/000/0", busy, buttons, drop_count); end
        @(negedge clk);
        reset = 1'b1;
        run_pkt(8'h08, 8'h0A, 8'h00); model_pkt(8'h08, 8'h0A, 8'h00);
        checks++; if (o_x !== 8'(exp_x) || o_moved3 !== 1'b1) begin failures++; $display("FAIL after_reset got=%0d/%b exp=%0d/1", o_x, o_moved3, exp_x); end
    endtask

    initial begin
        reset = 1'b0;
        enable_send = 1'b1;
        pkt_if.packet_valid = 1'b0;
        pkt_if.status = 8'h00; pkt_if.dx = 8'h00; pkt_if.dy = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_motion();
        test_clamp();
        test_buttons();
        test_ovf_sync();
        test_back_to_back();
        test_enable();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
